// File: rtl/conv_layer_ctrl_pkg.sv
// conv_pkg: shared sizes, sequencer state type and Q8.8 output helper for
// conv_layer_ctrl and its MAC datapath.
package conv_pkg;

   localparam int unsigned DATA_W    = 16;
   localparam int unsigned BUF_DEPTH = 1024;
   localparam int unsigned MAX_K     = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_F,
      COPY_F,
      LOAD_I,
      CONV,
      EMIT,
      DONE
   } convState_t;

   // Drop the 8 fractional bits of the 32-bit accumulator (arithmetic shift)
   // and clamp to the signed 16-bit Q8.8 range.
   function automatic logic signed [15:0] q88Sat(input logic signed [31:0] acc);
      logic signed [31:0] shifted;
      shifted = acc >>> 8;
      if (shifted > 32'sd32767)
         return 16'sh7FFF;
      else if (shifted < -32'sd32768)
         return 16'sh8000;
      else
         return shifted[15:0];
   endfunction

endpackage

// File: rtl/conv_layer_ctrl_if.sv
// conv_layer_ctrl_if: load_block request/response bus plus the result stream.
//   master (controller): drives loadAddr/loadSize/loadEnable and
//                        resValid/resData/resIndex; receives loadDone/loadOut.
//   slave  (memory side / sink): the mirror image.
interface conv_layer_ctrl_if #(
   parameter int unsigned DATA_W    = conv_pkg::DATA_W,
   parameter int unsigned BUF_DEPTH = conv_pkg::BUF_DEPTH
) ();

   logic        [DATA_W-1:0] loadAddr;
   logic        [DATA_W-1:0] loadSize;
   logic                     loadEnable;
   logic                     loadDone;
   logic signed [DATA_W-1:0] loadOut [BUF_DEPTH];
   logic                     resValid;
   logic signed [DATA_W-1:0] resData;
   logic        [DATA_W-1:0] resIndex;

   modport master (
      output loadAddr, loadSize, loadEnable, resValid, resData, resIndex,
      input  loadDone, loadOut
   );

   modport slave (
      input  loadAddr, loadSize, loadEnable, resValid, resData, resIndex,
      output loadDone, loadOut
   );

endinterface

// File: rtl/conv_layer_ctrl_mac.sv
// conv_mac: 32-bit signed multiply-accumulate with synchronous clear and a
// saturated Q8.8 view of the accumulator.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : zero the accumulator (wins over accEn)
//   accEn      : acc += pixel * weight (wraps at 32 bits)
//   pixel      : signed image word
//   weight     : signed filter word
//   satOut     : (acc >>> 8) clamped to [-32768, 32767]
module conv_mac #(
   parameter int unsigned DATA_W = conv_pkg::DATA_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     accEn,
   input  logic signed [DATA_W-1:0] pixel,
   input  logic signed [DATA_W-1:0] weight,
   output logic signed [DATA_W-1:0] satOut
);
   import conv_pkg::*;

   logic signed [2*DATA_W-1:0] acc;
   logic signed [2*DATA_W-1:0] prod;

   assign prod = (2*DATA_W)'(pixel) * (2*DATA_W)'(weight);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (accEn)
         acc <= acc + prod;
   end

   assign satOut = q88Sat(acc);

endmodule

// File: rtl/conv_layer_ctrl.sv
// conv_layer_ctrl: sequences filter/image loads through load_block and runs a
// stride-1, no-padding 2-D convolution of every image with every filter
// (filter-major), emitting one Q8.8 word per output pixel.
//   clk, reset        : clock, asynchronous active-high reset
//   enable            : start/run, must stay high for the whole job
//   imgsNumber/imgSize/imgsAddress       : image count N, side S, base address
//   filtersNumber/filterSize/filterAddress : filter count F, side K, base address
//   bus (master)      : load_block request/response and result stream
//   done              : job complete, held until enable drops
module conv_layer_ctrl #(
   parameter int unsigned DATA_W    = conv_pkg::DATA_W,
   parameter int unsigned BUF_DEPTH = conv_pkg::BUF_DEPTH,
   parameter int unsigned MAX_K     = conv_pkg::MAX_K
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [DATA_W-1:0] imgsNumber,
   input  logic [DATA_W-1:0] imgSize,
   input  logic [DATA_W-1:0] imgsAddress,
   input  logic [DATA_W-1:0] filtersNumber,
   input  logic [DATA_W-1:0] filterSize,
   input  logic [DATA_W-1:0] filterAddress,
   conv_layer_ctrl_if.master bus,
   output logic              done
);
   import conv_pkg::*;

   localparam int unsigned IDX_W  = $clog2(BUF_DEPTH);
   localparam int unsigned FIDX_W = $clog2(MAX_K*MAX_K);

   convState_t state, nextState;

   logic        [DATA_W-1:0] nImg, sImg, iBase, nFilt, kSide, fBase;
   logic        [DATA_W-1:0] fCnt, iCnt, rCnt, cCnt, uCnt, vCnt, resIdx;
   logic        [DATA_W-1:0] kk, ss, oSide;
   logic        [IDX_W-1:0]  pixIdx;
   logic        [FIDX_W-1:0] filtIdx;
   logic signed [DATA_W-1:0] filt [MAX_K*MAX_K];
   logic signed [DATA_W-1:0] pixel, weight, macOut;
   logic lastF, lastI, lastR, lastC, lastU, lastV;
   logic badJob, abort, macClr, macEn;

   assign kk    = kSide * kSide;
   assign ss    = sImg * sImg;
   assign oSide = sImg - kSide + 16'd1;

   assign lastF = (fCnt == nFilt - 16'd1);
   assign lastI = (iCnt == nImg - 16'd1);
   assign lastR = (rCnt == oSide - 16'd1);
   assign lastC = (cCnt == oSide - 16'd1);
   assign lastU = (uCnt == kSide - 16'd1);
   assign lastV = (vCnt == kSide - 16'd1);

   // Checked against the live inputs because they are latched in the same cycle.
   assign badJob = (imgsNumber == '0) || (filtersNumber == '0) || (filterSize == '0) ||
                   (filterSize > imgSize) || (filterSize > DATA_W'(MAX_K));

   assign abort = (state != IDLE) && (state != DONE) && !enable;

   assign pixIdx  = IDX_W'((rCnt + uCnt) * sImg + cCnt + vCnt);
   assign filtIdx = FIDX_W'(uCnt * kSide + vCnt);
   assign pixel   = bus.loadOut[pixIdx];
   assign weight  = filt[filtIdx];

   conv_mac #(.DATA_W(DATA_W)) uMac (
      .clk    (clk),
      .reset  (reset),
      .clr    (macClr),
      .accEn  (macEn),
      .pixel  (pixel),
      .weight (weight),
      .satOut (macOut)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= nextState;
   end

   always_comb begin
      nextState = state;
      macClr    = 1'b0;
      macEn     = 1'b0;
      if (abort) begin
         nextState = IDLE;
         macClr    = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               macClr = 1'b1;
               if (enable)
                  nextState = badJob ? DONE : LOAD_F;
            end
            LOAD_F: if (bus.loadDone) nextState = COPY_F;
            COPY_F: nextState = LOAD_I;
            LOAD_I: if (bus.loadDone) nextState = CONV;
            CONV: begin
               macEn = 1'b1;
               if (lastU && lastV)
                  nextState = EMIT;
            end
            EMIT: begin
               macClr = 1'b1;
               if (lastC && lastR) begin
                  if (lastI)
                     nextState = lastF ? DONE : LOAD_F;
                  else
                     nextState = LOAD_I;
               end else begin
                  nextState = CONV;
               end
            end
            DONE: if (!enable) nextState = IDLE;
            default: nextState = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.loadEnable = 1'b0;
      bus.loadAddr   = '0;
      bus.loadSize   = '0;
      case (state)
         LOAD_F: begin
            bus.loadEnable = 1'b1;
            bus.loadAddr   = fBase + fCnt * kk;
            bus.loadSize   = kk;
         end
         LOAD_I: begin
            bus.loadEnable = 1'b1;
            bus.loadAddr   = iBase + iCnt * ss;
            bus.loadSize   = ss;
         end
         default: ;
      endcase
      bus.resValid = (state == EMIT);
      bus.resData  = (state == EMIT) ? macOut : '0;
      bus.resIndex = resIdx;
      done         = (state == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         {nImg, sImg, iBase, nFilt, kSide, fBase} <= '0;
         {fCnt, iCnt, rCnt, cCnt, uCnt, vCnt}     <= '0;
         resIdx                                   <= '0;
      end else if (abort) begin
         {fCnt, iCnt, rCnt, cCnt, uCnt, vCnt} <= '0;
         resIdx                               <= '0;
      end else begin
         case (state)
            IDLE: if (enable) begin
               nImg  <= imgsNumber;
               sImg  <= imgSize;
               iBase <= imgsAddress;
               nFilt <= filtersNumber;
               kSide <= filterSize;
               fBase <= filterAddress;
               {fCnt, iCnt, rCnt, cCnt, uCnt, vCnt} <= '0;
               resIdx <= '0;
            end
            CONV: begin
               if (lastV) begin
                  vCnt <= '0;
                  uCnt <= lastU ? '0 : uCnt + 16'd1;
               end else begin
                  vCnt <= vCnt + 16'd1;
               end
            end
            EMIT: begin
               resIdx <= resIdx + 16'd1;
               if (!lastC) begin
                  cCnt <= cCnt + 16'd1;
               end else begin
                  cCnt <= '0;
                  if (!lastR) begin
                     rCnt <= rCnt + 16'd1;
                  end else begin
                     rCnt <= '0;
                     if (lastI) begin
                        iCnt <= '0;
                        fCnt <= fCnt + 16'd1;
                     end else begin
                        iCnt <= iCnt + 16'd1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Words past K*K are copied too; they are never addressed by filtIdx.
   always_ff @(posedge clk) begin
      if (state == COPY_F)
         for (int unsigned k = 0; k < MAX_K*MAX_K; k++)
            filt[k] <= bus.loadOut[k];
   end

endmodule

// File: tb/tb_conv_layer_ctrl.sv
module tb_conv_layer_ctrl;
   import conv_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] imgsNumber, imgSize, imgsAddress;
   logic [15:0] filtersNumber, filterSize, filterAddress;
   logic        done;

   conv_layer_ctrl_if #(.DATA_W(16), .BUF_DEPTH(1024)) bus ();

   conv_layer_ctrl #(.DATA_W(16), .BUF_DEPTH(1024), .MAX_K(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .imgsNumber    (imgsNumber),
      .imgSize       (imgSize),
      .imgsAddress   (imgsAddress),
      .filtersNumber (filtersNumber),
      .filterSize    (filterSize),
      .filterAddress (filterAddress),
      .bus           (bus),
      .done          (done)
   );

   always #5 clk = ~clk;

   // ---------------- memory + load_block model ----------------
   typedef struct {
      logic [15:0] addr;
      logic [15:0] size;
   } loadReq_t;

   logic [15:0] mem [65536];
   loadReq_t    loadLog[$];
   int          ldState, ldCnt;
   logic [15:0] ldAddr, ldSize;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ldState      <= 0;
         ldCnt        <= 0;
         bus.loadDone <= 1'b0;
      end else begin
         case (ldState)
            0: if (bus.loadEnable) begin
               loadLog.push_back('{bus.loadAddr, bus.loadSize});
               ldAddr  <= bus.loadAddr;
               ldSize  <= bus.loadSize;
               ldCnt   <= 2;
               ldState <= 1;
            end
            1: if (ldCnt == 0) begin
               for (int k = 0; k < 1024; k++)
                  if (k < int'(ldSize)) bus.loadOut[k] <= mem[16'(ldAddr + 16'(k))];
               bus.loadDone <= 1'b1;
               ldState      <= 2;
            end else begin
               ldCnt <= ldCnt - 1;
            end
            default: begin
               bus.loadDone <= 1'b0;
               ldState      <= 0;
            end
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [15:0] idx;
      logic [15:0] data;
   } exp_t;

   exp_t        sbQ[$];
   int          tests = 0;
   int          fails = 0;
   int          resCount = 0;
   int          expTotal = 0;
   logic [15:0] firstData;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus.resValid) begin
         resCount++;
         if (resCount == 1) firstData = bus.resData;
         if (sbQ.size() == 0) begin
            check("result overflow", resCount, expTotal);
         end else begin
            e = sbQ.pop_front();
            check("resData", {16'h0, bus.resData}, {16'h0, e.data});
            check("resIndex", {16'h0, bus.resIndex}, {16'h0, e.idx});
         end
      end
   end

   function automatic logic [15:0] refSat(input int a);
      int s;
      s = a >>> 8;
      if (s > 32767) return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return s[15:0];
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      string       name;
      int          n, s, iA, f, k, fA;
      logic [15:0] imgVal, filtVal;
      bit          randMem;
      int          expResults, expLoads;
      logic [15:0] expAddr0, expSize0;
      int          maxCycles;    // 0 = no latency bound to check
      bit          checkFirst;
      logic [15:0] expFirst;
   } vec_t;

   vec_t vecs[9];

   task automatic buildExpected(input vec_t v);
      int o, acc;
      logic [15:0] idx, pa, fa;
      logic signed [15:0] p, w;
      idx = 16'd0;
      o = v.s - v.k + 1;
      for (int fi = 0; fi < v.f; fi++)
         for (int ii = 0; ii < v.n; ii++)
            for (int r = 0; r < o; r++)
               for (int c = 0; c < o; c++) begin
                  acc = 0;
                  for (int uu = 0; uu < v.k; uu++)
                     for (int vv = 0; vv < v.k; vv++) begin
                        pa = 16'(v.iA + ii*v.s*v.s + (r+uu)*v.s + c + vv);
                        fa = 16'(v.fA + fi*v.k*v.k + uu*v.k + vv);
                        p = mem[pa];
                        w = mem[fa];
                        acc = acc + int'(p) * int'(w);
                     end
                  sbQ.push_back('{idx, refSat(acc)});
                  idx = idx + 16'd1;
               end
   endtask

   task automatic setupVec(input vec_t v);
      sbQ.delete();
      loadLog.delete();
      resCount = 0;
      expTotal = v.expResults;
      for (int j = 0; j < v.n*v.s*v.s; j++)
         mem[16'(v.iA + j)] = v.randMem ? 16'($urandom) : v.imgVal;
      for (int j = 0; j < v.f*v.k*v.k; j++)
         mem[16'(v.fA + j)] = v.randMem ? 16'($urandom) : v.filtVal;
      if (v.expResults > 0) buildExpected(v);
      @(negedge clk);
      imgsNumber    = 16'(v.n);
      imgSize       = 16'(v.s);
      imgsAddress   = 16'(v.iA);
      filtersNumber = 16'(v.f);
      filterSize    = 16'(v.k);
      filterAddress = 16'(v.fA);
   endtask

   task automatic waitDone(output int cycles);
      cycles = 0;
      while (!done && cycles < 30000) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic runVec(input vec_t v);
      int cycles;
      setupVec(v);
      enable = 1'b1;
      waitDone(cycles);
      check({v.name, " done"}, done, 1);
      check({v.name, " results"}, resCount, v.expResults);
      check({v.name, " scoreboard drained"}, sbQ.size(), 0);
      check({v.name, " loads"}, loadLog.size(), v.expLoads);
      if (v.expLoads > 0 && loadLog.size() > 0) begin
         check({v.name, " load0 addr"}, loadLog[0].addr, v.expAddr0);
         check({v.name, " load0 size"}, loadLog[0].size, v.expSize0);
      end
      if (v.maxCycles > 0) check({v.name, " done latency ok"}, cycles <= v.maxCycles, 1);
      if (v.checkFirst && resCount > 0) check({v.name, " first data"}, firstData, v.expFirst);
      @(negedge clk);
      enable = 1'b0;
      @(posedge clk);
      #1;
      check({v.name, " done cleared"}, done, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      //            name       n  s   iA   f  k  fA     img      filt     rnd res  ld  a0     s0   max first   expFirst
      vecs[0] = '{"ref",       3, 10, 0,    6, 5, 300,   16'h0100, 16'h0100, 0, 648, 24, 300,   25,  0, 1, 16'h1900};
      vecs[1] = '{"satPos",    1, 5,  0,    1, 5, 100,   16'h7FFF, 16'h7FFF, 0, 1,   2,  100,   25,  0, 1, 16'h7FFF};
      vecs[2] = '{"satNeg",    1, 5,  0,    1, 5, 100,   16'h7FFF, 16'h8000, 0, 1,   2,  100,   25,  0, 1, 16'h8000};
      vecs[3] = '{"random",    2, 6,  1000, 2, 3, 65530, 16'h0,    16'h0,    1, 64,  6,  65530, 9,   0, 0, 16'h0};
      vecs[4] = '{"kMax",      1, 8,  0,    1, 8, 200,   16'h0100, 16'h0100, 0, 1,   2,  200,   64,  0, 1, 16'h4000};
      vecs[5] = '{"nZero",     0, 5,  0,    1, 3, 100,   16'h0100, 16'h0100, 0, 0,   0,  0,     0,   2, 0, 16'h0};
      vecs[6] = '{"kGtS",      1, 5,  0,    1, 6, 100,   16'h0100, 16'h0100, 0, 0,   0,  0,     0,   2, 0, 16'h0};
      vecs[7] = '{"kGtMax",    1, 10, 0,    1, 9, 200,   16'h0100, 16'h0100, 0, 0,   0,  0,     0,   2, 0, 16'h0};
      vecs[8] = '{"fZero",     1, 5,  0,    0, 3, 100,   16'h0100, 16'h0100, 0, 0,   0,  0,     0,   2, 0, 16'h0};

      reset = 1'b1;
      enable = 1'b0;
      {imgsNumber, imgSize, imgsAddress, filtersNumber, filterSize, filterAddress} = '0;
      #12;
      check("reset loadEnable", bus.loadEnable, 0);
      check("reset outputs", {bus.loadAddr, bus.loadSize}, 0);
      check("reset result", {bus.resValid, bus.resData, bus.resIndex, done}, 0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[t]) runVec(vecs[t]);

      // Address sequencing of the reference job: F0 I0 I1 I2 F1 ...
      runVec(vecs[0]);
      if (loadLog.size() >= 5) begin
         check("ref load1 addr", loadLog[1].addr, 16'd0);
         check("ref load1 size", loadLog[1].size, 16'd100);
         check("ref image2 addr", loadLog[3].addr, 16'd200);
         check("ref filter1 addr", loadLog[4].addr, 16'd325);
      end else begin
         check("ref load log length", loadLog.size(), 24);
      end

      // Asynchronous reset in the middle of CONV, then restart with enable held.
      setupVec(vecs[3]);
      enable = 1'b1;
      cyc = 0;
      while (resCount < 3 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      check("midconv reached results", resCount >= 3, 1);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("async reset loadEnable", bus.loadEnable, 0);
      check("async reset outputs", {bus.loadAddr, bus.loadSize}, 0);
      check("async reset result", {bus.resValid, bus.resData, bus.resIndex, done}, 0);
      sbQ.delete();
      loadLog.delete();
      resCount = 0;
      buildExpected(vecs[3]);
      @(negedge clk);
      reset = 1'b0;
      waitDone(cyc);
      check("restart done", done, 1);
      check("restart first load addr", loadLog.size() > 0 ? loadLog[0].addr : 16'hDEAD, 16'd65530);
      check("restart results", resCount, 64);
      check("restart scoreboard drained", sbQ.size(), 0);
      @(negedge clk);
      enable = 1'b0;
      @(posedge clk);
      #1;
      check("restart done cleared", done, 0);

      // enable dropped while LOAD_I is waiting on load_block.
      setupVec(vecs[0]);
      sbQ.delete();
      enable = 1'b1;
      cyc = 0;
      while (loadLog.size() < 2 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("abort reached LOAD_I", loadLog.size(), 2);
      enable = 1'b0;
      @(posedge clk);
      #1;
      check("abort loadEnable", bus.loadEnable, 0);
      check("abort state idle", dut.state == IDLE, 1);
      check("abort done", done, 0);
      repeat (6) @(posedge clk);
      #1;
      check("abort stays idle", {bus.loadEnable, done, bus.resValid}, 0);
      check("abort no results", resCount, 0);
      check("abort no new loads", loadLog.size(), 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/conv_layer_ctrl.md
Name: conv_layer_ctrl

Overview:
- Convolution-layer sequencer plus MAC datapath. Fetches filters and input images from memory through the existing block loader (load_block, which is backed by DMA).
- Computes stride-1, no-padding 2-D convolution of every image with every filter.
- Streams Q8.8 results out one word per output pixel.
- Sits between the top-level layer scheduler and the load_block/DMA memory path.

Parameters:
- DATA_W, 16, word width of pixels, weights and addresses.
- BUF_DEPTH, 1024, number of words in the load_block output bus (loadOut).
- MAX_K, 8, maximum filter side; the local filter buffer holds MAX_K*MAX_K words.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  start/run; must stay high for the whole job.
- loadDone  in  1  load_block completion flag.
- imgsNumber  in  16  number of input images N.
- imgSize  in  16  image side S (S*S <= BUF_DEPTH).
- imgsAddress  in  16  base word address of image 0; images are contiguous, S*S words each, row-major.
- filtersNumber  in  16  number of filters F.
- filterSize  in  16  filter side K (K <= MAX_K).
- filterAddress  in  16  base address of filter 0; filters are contiguous, K*K words each, row-major.
- loadAddr  out  16  start address for load_block.
- loadSize  out  16  word count for load_block.
- loadOut  in  BUF_DEPTH x 16 signed  words returned by load_block; index 0 = loadAddr.
- loadEnable  out  1  load request.
- resValid  out  1  one-cycle strobe, result word valid.
- resData  out  16 signed  result pixel, Q8.8.
- resIndex  out  16  running output index, starting at 0.
- done  out  1  job complete.

Behaviour:
- Reset (asynchronous) forces state IDLE. All outputs go to 0: loadAddr, loadSize, loadEnable, resValid, resData, resIndex, done. Counters and accumulator clear.
- Output side O = S-K+1.
- Loop order: filter-major. For f = 0..F-1, for i = 0..N-1, emit the O*O map row-major.
- Total results = F*N*O*O. resIndex counts continuously across all maps.

State machine:
- IDLE: wait for enable=1.
  - Latch all size/address inputs.
  - If N=0, F=0, K=0, K>S or K>MAX_K, go to DONE.
  - Otherwise go to LOAD_F.
- LOAD_F:
  - Drive loadAddr = filterAddress + f*K*K and loadSize = K*K.
  - Assert loadEnable until loadDone=1 is sampled, then deassert loadEnable and go to COPY_F.
- COPY_F: copy loadOut[0..K*K-1] into the local filter buffer in one cycle, then go to LOAD_I.
- LOAD_I:
  - Drive loadAddr = imgsAddress + i*S*S and loadSize = S*S.
  - Use the same handshake as LOAD_F, then go to CONV.
  - Image words are read directly from loadOut, which stays stable until the next load.
- CONV:
  - One MAC per cycle: acc += loadOut[(r+u)*S + (c+v)] * filt[u*K+v].
  - Products are signed 16x16 -> 32 bits; acc is 32-bit signed and wraps.
  - Exactly K*K cycles per output pixel, then go to EMIT.
- EMIT: one cycle.
  - resData = acc >> 8 (arithmetic shift), saturated to [-32768, 32767].
  - Assert resValid; after the cycle, resIndex increments and acc clears.
  - Advance c, then r.
  - When the map finishes, advance i and return to LOAD_I.
  - When i wraps, advance f and return to LOAD_F.
  - After the last map, go to DONE.
- DONE: done=1 held until enable=0, then return to IDLE with done=0.

Handshake and boundary rules:
- enable falling anywhere other than IDLE/DONE aborts: next cycle is IDLE, loadEnable=0 and counters clear.
- loadDone is ignored while loadEnable=0.
- Address arithmetic wraps modulo 2^16.
- Inputs are only sampled in IDLE.

Decomposition:
- Shared package conv_pkg holds:
  - DATA_W, BUF_DEPTH, MAX_K;
  - a state enum typedef;
  - a Q8.8 saturate-and-shift function.
- One natural sub-module: conv_mac, the 32-bit accumulator with clear/accumulate controls and a saturating Q8.8 output.

Test Plan:
- Reference job: N=3, S=10, imgsAddress=0, F=6, K=5, filterAddress=300, all memory words 0x0100.
  - First request must be loadAddr=300, loadSize=25; the second must be loadAddr=0, loadSize=100.
  - 648 resValid strobes, every resData=0x1900 (25.0).
  - done=1 after the last strobe.
- Address sequencing, same job:
  - the filter-1 load uses loadAddr=325;
  - the image-2 load uses loadAddr=200;
  - resIndex runs 0..647 with no gaps.
- Saturation, images and filters all 0x7FFF, N=1, F=1, S=5, K=5: a single result 0x7FFF. With filters all 0x8000: a single result 0x8000.
- Degenerate inputs:
  - N=0: done=1 within 2 cycles of enable, with no load requests.
  - K=6, S=5: same response, done with no loads and no results.
- Reset mid-CONV: assert reset asynchronously; outputs are 0 immediately. After release with enable=1, the job restarts from filter 0 at loadAddr=filterAddress.
- enable dropped during LOAD_I: next cycle loadEnable=0 and state IDLE, done stays 0.
